// File: rtl/inst_intensity_gen_if.sv
// inst_intensity_gen_if: raster position, drum triggers and published per-instrument intensity.
interface inst_intensity_gen_if #(parameter int N = 3);
  logic [10:0] h_count;
  logic [9:0] v_count;
  logic [N-1:0] trig;
  logic [N-1:0][6:0] velocity;
  logic [9:0] decay;
  logic [N-1:0][7:0] intensity;
  logic update_busy;
  modport master(output h_count, v_count, trig, velocity, decay, input intensity, update_busy);
  modport slave(input h_count, v_count, trig, velocity, decay, output intensity, update_busy);
endinterface

// File: rtl/inst_intensity_gen.sv
// inst_intensity_gen: frame-quantized hold/decay envelope per instrument from velocity triggers,
// updated once per frame with one multiplier shared across lanes.
module inst_intensity_gen #(
  parameter int INSTRUMENT_COUNT = 3,
  parameter int FRAME_TICK_V = 722,
  parameter int HOLD_FRAMES = 2,
  parameter int MIN_LEVEL = 2
) (
  input logic clk,
  input logic rst,
  inst_intensity_gen_if.slave bus
);
  localparam int N = INSTRUMENT_COUNT;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  typedef enum logic [1:0] {S_IDLE, S_PROC, S_PUBLISH} seq_t;
  typedef enum logic [1:0] {L_IDLE, L_HOLD, L_DECAY} lane_t;
  seq_t seq;
  lane_t st [N];
  logic [KW-1:0] k;
  logic [N-1:0][14:0] level_fp;
  logic [N-1:0][HW-1:0] hold_cnt;
  logic [N-1:0] pend, pend_nx, clr, hit;
  logic [N-1:0][6:0] pvel, pvel_nx, base_v;
  logic [7:0] keep;
  logic [14:0] next_fp;
  logic tick;
  assign tick = bus.h_count == 11'd0 && bus.v_count == 10'(FRAME_TICK_V);
  assign keep = 8'd255 - bus.decay[9:2];
  assign next_fp = 15'((23'(level_fp[k]) * 23'(keep)) >> 8);
  // a trigger landing on the lane being consumed survives: set wins over clear
  always_comb begin
    clr = '0;
    hit = '0;
    base_v = '0;
    pvel_nx = '0;
    pend_nx = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = seq == S_PROC && k == KW'(i);
      hit[i] = bus.trig[i] && bus.velocity[i] != 7'd0;
      base_v[i] = clr[i] ? 7'd0 : pvel[i];
      pvel_nx[i] = hit[i] && bus.velocity[i] > base_v[i] ? bus.velocity[i] : base_v[i];
      pend_nx[i] = hit[i] || (pend[i] && !clr[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      seq <= S_IDLE;
      k <= '0;
      bus.update_busy <= 1'b0;
      bus.intensity <= '0;
      pend <= '0;
      pvel <= '0;
      level_fp <= '0;
      hold_cnt <= '0;
      for (int i = 0; i < N; i++) st[i] <= L_IDLE;
    end else begin
      pend <= pend_nx;
      pvel <= pvel_nx;
      case (seq)
        S_IDLE: if (tick) begin
          seq <= S_PROC;
          k <= '0;
          bus.update_busy <= 1'b1;
        end
        S_PROC: begin
          if (pend[k]) begin
            level_fp[k] <= {pvel[k], 8'h00};
            hold_cnt[k] <= HW'(HOLD_FRAMES);
            st[k] <= L_HOLD;
          end else if (st[k] == L_HOLD) begin
            if (hold_cnt[k] == HW'(1)) st[k] <= L_DECAY;
            else hold_cnt[k] <= hold_cnt[k] - 1'b1;
          end else if (st[k] == L_DECAY) begin
            if (next_fp[14:8] < 7'(MIN_LEVEL)) begin
              st[k] <= L_IDLE;
              level_fp[k] <= '0;
            end else level_fp[k] <= next_fp;
          end
          if (k == KW'(N - 1)) seq <= S_PUBLISH;
          else k <= k + 1'b1;
        end
        S_PUBLISH: begin
          for (int i = 0; i < N; i++)
            bus.intensity[i] <= st[i] != L_IDLE ? {1'b1, level_fp[i][14:8]} : 8'h00;
          bus.update_busy <= 1'b0;
          seq <= S_IDLE;
        end
        default: seq <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_intensity_gen.sv
// tb_inst_intensity_gen: directed plus random trigger frames checked against an age-based envelope model.
module tb_inst_intensity_gen;
  localparam int N = 3, TV = 722, HOLD = 2, MINL = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0;
  int m_act[N], m_lvl[N], m_age[N], m_pend[N];
  always #5 clk = ~clk;
  inst_intensity_gen_if #(.N(N)) bus();
  inst_intensity_gen #(.INSTRUMENT_COUNT(N), .FRAME_TICK_V(TV), .HOLD_FRAMES(HOLD), .MIN_LEVEL(MINL))
    dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pub(int i);
    return m_act[i] != 0 ? {1'b1, 7'(m_lvl[i] / 256)} : 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_lvl[i] = 0; m_age[i] = 0; m_pend[i] = 0;
    end
  endtask

  task automatic model_trig(int i, int v);
    if (v > m_pend[i]) m_pend[i] = v;
  endtask

  // lane age counts frames since its trigger; decay applies once age exceeds the hold window
  task automatic model_frame(int keep);
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] > 0) begin
        m_lvl[i] = m_pend[i] * 256; m_age[i] = 0; m_act[i] = 1; m_pend[i] = 0;
      end else if (m_act[i] != 0) begin
        m_age[i]++;
        if (m_age[i] > HOLD) begin
          m_lvl[i] = (m_lvl[i] * keep) / 256;
          if (m_lvl[i] / 256 < MINL) begin m_act[i] = 0; m_lvl[i] = 0; end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    bus.trig = '0;
    bus.h_count = 11'($urandom_range(1, 1500));
    bus.v_count = 10'($urandom_range(0, 721));
  endtask

  task automatic trig_one(int i, int v);
    step();
    bus.trig[i] = 1'b1;
    bus.velocity[i] = 7'(v);
    model_trig(i, v);
  endtask

  task automatic idle(int cycles, bit rnd);
    repeat (cycles) begin
      step();
      for (int i = 0; i < N; i++) begin
        bus.velocity[i] = 7'($urandom_range(0, 127));
        if (rnd && $urandom_range(0, 5) == 0) begin
          bus.trig[i] = 1'b1;
          model_trig(i, int'(bus.velocity[i]));
        end
      end
    end
  endtask

  // tick at T, optional trigger or reset injected at T+2, publish checked at T+N+2
  task automatic frame(int inj_lane, int inj_vel, bit inj_rst);
    logic [7:0] old[N];
    int keep;
    keep = 255 - int'(bus.decay[9:2]);
    for (int i = 0; i < N; i++) old[i] = pub(i);
    step();
    bus.h_count = 11'd0;
    bus.v_count = 10'(TV);
    chk("busy_at_T", bus.update_busy, 0);
    for (int c = 1; c <= N + 1; c++) begin
      step();
      chk($sformatf("busy_T+%0d", c), bus.update_busy, 1);
      if (c == 2 && inj_rst) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        chk("busy_after_rst", bus.update_busy, 0);
        for (int i = 0; i < N; i++) chk($sformatf("int%0d_after_rst", i), bus.intensity[i], 8'h00);
        return;
      end
      if (c == 2 && inj_lane >= 0) begin
        bus.trig[inj_lane] = 1'b1;
        bus.velocity[inj_lane] = 7'(inj_vel);
      end
      if (c == N + 1)
        for (int i = 0; i < N; i++) chk($sformatf("int%0d_hold_pre_publish", i), bus.intensity[i], old[i]);
    end
    if (inj_lane > 1) model_trig(inj_lane, inj_vel);
    model_frame(keep);
    if (inj_lane >= 0 && inj_lane <= 1) model_trig(inj_lane, inj_vel);
    step();
    chk("busy_after_publish", bus.update_busy, 0);
    for (int i = 0; i < N; i++) chk($sformatf("int%0d_publish", i), bus.intensity[i], pub(i));
  endtask

  initial begin
    model_reset();
    bus.trig = '0;
    bus.velocity = '0;
    bus.decay = 10'h200;
    bus.h_count = 11'd5;
    bus.v_count = 10'd5;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", bus.update_busy, 0);
    for (int i = 0; i < N; i++) chk($sformatf("reset_int%0d", i), bus.intensity[i], 8'h00);
    idle(5, 0);
    frame(-1, 0, 0);
    frame(-1, 0, 0);
    // hold then decay with keep=127
    trig_one(0, 100);
    idle(3, 0);
    frame(-1, 0, 0); chk("plan_F0", bus.intensity[0], 8'hE4);
    frame(-1, 0, 0); chk("plan_F1", bus.intensity[0], 8'hE4);
    frame(-1, 0, 0); chk("plan_F2", bus.intensity[0], 8'hE4);
    frame(-1, 0, 0); chk("plan_F3", bus.intensity[0], 8'hB1);
    frame(-1, 0, 0); chk("plan_F4", bus.intensity[0], 8'h98);
    // keep=0 kills the lane on its first decay frame
    bus.decay = 10'h3FF;
    trig_one(1, 50);
    idle(2, 0);
    frame(-1, 0, 0); chk("kill_F0", bus.intensity[1], 8'hB2);
    frame(-1, 0, 0); chk("kill_F1", bus.intensity[1], 8'hB2);
    frame(-1, 0, 0); chk("kill_F2", bus.intensity[1], 8'hB2);
    frame(-1, 0, 0); chk("kill_F3", bus.intensity[1], 8'h00);
    // max of two triggers, zero-velocity trigger ignored
    bus.decay = 10'h100;
    trig_one(2, 30);
    idle(2, 0);
    trig_one(2, 90);
    trig_one(0, 0);
    idle(2, 0);
    frame(-1, 0, 0);
    chk("max_vel_lane2", bus.intensity[2], 8'hDA);
    chk("zero_vel_lane0", bus.intensity[0], 8'h00);
    // trigger on the lane being processed lands one frame late
    frame(1, 64, 0); chk("late_trig_F", bus.intensity[1], 8'h00);
    frame(-1, 0, 0); chk("late_trig_F1", bus.intensity[1], 8'hC0);
    for (int f = 0; f < 24; f++) begin
      bus.decay = 10'($urandom_range(0, 1023));
      idle($urandom_range(2, 10), 1);
      if ($urandom_range(0, 2) == 0) frame(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 127)), 0);
      else frame(-1, 0, 0);
    end
    // reset in the middle of an update, pending trigger discarded
    trig_one(0, 77);
    idle(2, 0);
    frame(2, 55, 1);
    idle(3, 0);
    frame(-1, 0, 0);
    for (int i = 0; i < N; i++) chk($sformatf("post_rst_int%0d", i), bus.intensity[i], 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
